fpu_addsub: RTL and testbench
=============================

FPU_ADDSUB -- requirements
Module: fpu_addsub

Interface
REQ-001 The module SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The module SHALL have parameter MANT_W, default 7, stored mantissa width; the leading 1 is implied.
REQ-003 The module SHALL have parameter BIAS, default 127, exponent bias; word width W = 1+EXP_W+MANT_W.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit, request to begin an operation.
REQ-007 The module SHALL have port sub, input, 1 bit: 0 = op1+op2, 1 = op1-op2.
REQ-008 The module SHALL have ports op1 and op2, input, W bits each, with layout {sign, exponent, mantissa}.
REQ-009 The module SHALL have port result, output, W bits, the registered result.
REQ-010 The module SHALL have port done, output, 1 bit, a one-cycle pulse when result is valid.
REQ-011 The module SHALL have port busy, output, 1 bit, high while an operation is in flight.
REQ-012 The module SHALL have port ovf, output, 1 bit, exponent overflow flag, valid with done.
REQ-013 The module SHALL have port unf, output, 1 bit, underflow (flushed to zero) flag, valid with done.

Function
REQ-014 The FSM SHALL have states IDLE, ALIGN, ADD, NORM, FIN, with sequence IDLE->ALIGN->ADD->NORM->FIN->IDLE and one cycle per state.
REQ-015 start SHALL be sampled only when busy=0; op1, op2 and sub SHALL be captured on that edge, and start while busy=1 SHALL be ignored.
REQ-016 Latency SHALL be fixed: start sampled on edge N gives done=1 and a valid result after edge N+4.
REQ-017 done, result, ovf and unf SHALL update together; result, ovf and unf SHALL hold until the next done.
REQ-018 busy SHALL be 0 in the done cycle, and a start in that cycle SHALL be accepted, giving one result per 5 cycles back-to-back.
REQ-019 Any operand with exponent field 0 SHALL be treated as zero; denormals are not supported.
REQ-020 The effective op2 sign SHALL be op2.sign XOR sub, and an effective subtract SHALL occur when op1.sign differs from the effective op2 sign.
REQ-021 ALIGN SHALL order the operands by magnitude (exponent, then mantissa) and right-shift the smaller {1,mant} by the exponent difference; a difference > MANT_W+1 SHALL contribute 0.
REQ-022 ADD SHALL add or subtract the (MANT_W+2)-bit magnitudes, and the result sign SHALL be the sign of the larger-magnitude operand.
REQ-023 NORM on carry-out SHALL shift right 1 and increment the exponent; otherwise it SHALL left-shift by the leading-zero count and subtract that count from the exponent.
REQ-024 Rounding SHALL be truncation; bits shifted out SHALL be discarded.
REQ-025 A zero magnitude (equal-magnitude subtract, or both operands zero) SHALL give all-zero result (+0) with ovf=0 and unf=0.
REQ-026 If exactly one operand is zero, result SHALL be the other operand with its effective sign.
REQ-027 A normalised exponent < 1 SHALL produce result = 0 and unf=1.
REQ-028 A normalised exponent >= 2^EXP_W-1 SHALL produce ovf=1, with the result as set by REQ-031/REQ-032.

Reset
REQ-029 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, with result=0, done=0, busy=0, ovf=0, unf=0.
REQ-030 Reset mid-operation SHALL abort the operation, and no done SHALL follow for the aborted operation.

Configuration
REQ-031 With FPU_ADDSUB_SAT_EN defined, overflow SHALL yield {sign, 2^EXP_W-2, all-ones mantissa}, the maximum finite magnitude.
REQ-032 Without FPU_ADDSUB_SAT_EN, overflow SHALL yield the exponent truncated to EXP_W bits and the computed mantissa; ovf SHALL be raised in both builds.

Verification (default parameters)
REQ-033 Bench SHALL cover: 0x3F80 + 0x3F80, sub=0 -> result 0x4000 at N+4, done for one cycle, busy for 4 cycles.
REQ-034 Bench SHALL cover: 0x4040 + 0xBF80 -> 0x4000; 0x3FC0 - 0x3FC0 -> 0x0000, ovf=0, unf=0.
REQ-035 Bench SHALL cover: 0x4B00 + 0x3F80 -> 0x4B00 (alignment shift-out); 0x0000 - 0x3F80 -> 0xBF80.
REQ-036 Bench SHALL cover: 0x7F7F + 0x7F7F -> ovf=1, with result 0x7F7F when SAT_EN is defined and 0x7FFF when it is not.
REQ-037 Bench SHALL cover: 0x0100 - 0x00C0 -> result 0x0000, unf=1.
REQ-038 Bench SHALL cover: start held high through FIN gives back-to-back accepts, and rst_n=0 in state ADD gives no done, with busy=0 on the next cycle.

Source files
------------

// File: rtl/fpu_addsub.sv
// fpu_addsub: multi-cycle floating-point add/subtract, {sign, exponent, mantissa}
// format with implied leading one, truncation rounding, no denormals.
// Sequence IDLE -> ALIGN -> ADD -> NORM -> FIN, result registered on leaving FIN.
// Build option: define FPU_ADDSUB_SAT_EN to saturate overflow to the largest
// finite magnitude; otherwise the truncated exponent and computed mantissa are kept.
module fpu_addsub #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 7,
  parameter int BIAS   = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [EXP_W+MANT_W:0] op1,
  input  logic [EXP_W+MANT_W:0] op2,
  output logic [EXP_W+MANT_W:0] result,
  output logic                  done,
  output logic                  busy,
  output logic                  ovf,
  output logic                  unf
);
  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int MW  = MANT_W + 2;          // carry + hidden one + mantissa
  localparam int EW  = EXP_W + 3;           // signed working exponent
  localparam int LZW = $clog2(MW) + 1;
  localparam logic signed [EW-1:0]    BIAS_S    = EW'(BIAS);
  localparam logic signed [EW-1:0]    EMAX_S    = EW'((1 << EXP_W) - 2);
  localparam logic signed [EW-1:0]    ONE_S     = EW'(1);
  localparam logic [EXP_W-1:0]        SHIFT_LIM = EXP_W'(MANT_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Leading-zero count of a normalisation candidate (hidden-one position down).
  function automatic logic [LZW-1:0] lzc(input logic [MANT_W:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = MANT_W; i >= 0; i--) begin
      if (found) begin
        found = 1'b1;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        lzc = lzc + LZW'(1);
      end
    end
  endfunction

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic                   sub_q, sub_d;
  logic                   sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic                   pass_q, pass_d;
  logic [W-1:0]           pass_val_q, pass_val_d;
  logic [EXP_W-1:0]       big_exp_q, big_exp_d;
  logic [MW-1:0]          big_mag_q, big_mag_d, small_mag_q, small_mag_d;
  logic [MW-1:0]          sum_q, sum_d;
  logic                   zero_q, zero_d;
  logic signed [EW-1:0]   exp_q, exp_d;          // unbiased exponent
  logic [MANT_W-1:0]      mant_q, mant_d;
  logic [W-1:0]           result_q, result_d;
  logic                   done_q, done_d, busy_q, busy_d, ovf_q, ovf_d, unf_q, unf_d;

  // Combinational helpers for the alignment and normalisation stages.
  logic [EXP_W-1:0]       a_exp_s, b_exp_s, diff_s;
  logic                   a_zero_s, b_zero_s, b_sign_eff_s, a_ge_b_s;
  logic [MW-1:0]          small_raw_s;
  logic [LZW-1:0]         lz_s;
  logic [MANT_W-1:0]      norm_s;
  logic signed [EW-1:0]   big_unb_s, field_s;

  assign a_exp_s      = a_q[W-2:MANT_W];
  assign b_exp_s      = b_q[W-2:MANT_W];
  assign a_zero_s     = (a_exp_s == '0);
  assign b_zero_s     = (b_exp_s == '0);
  assign b_sign_eff_s = b_q[W-1] ^ sub_q;
  assign a_ge_b_s     = (a_q[W-2:0] >= b_q[W-2:0]);
  assign diff_s       = a_ge_b_s ? (a_exp_s - b_exp_s) : (b_exp_s - a_exp_s);
  assign small_raw_s  = a_ge_b_s ? {1'b0, 1'b1, b_q[MANT_W-1:0]} : {1'b0, 1'b1, a_q[MANT_W-1:0]};
  assign lz_s         = lzc(sum_q[MANT_W:0]);
  assign norm_s       = MANT_W'(sum_q[MANT_W:0] << lz_s);
  assign big_unb_s    = $signed(EW'(big_exp_q)) - BIAS_S;
  assign field_s      = exp_q + BIAS_S;

  // Next-state and datapath: each state does its own step, everything else holds.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    pass_d      = pass_q;
    pass_val_d  = pass_val_q;
    big_exp_d   = big_exp_q;
    big_mag_d   = big_mag_q;
    small_mag_d = small_mag_q;
    sum_d       = sum_q;
    zero_d      = zero_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ALIGN;
          a_d     = op1;
          b_d     = op2;
          sub_d   = sub;
        end else begin
          state_d = IDLE;
        end
      end
      ALIGN: begin
        state_d     = ADD;
        sign_d      = a_ge_b_s ? a_q[W-1] : b_sign_eff_s;
        eff_sub_d   = a_q[W-1] ^ b_sign_eff_s;
        big_exp_d   = a_ge_b_s ? a_exp_s : b_exp_s;
        big_mag_d   = a_ge_b_s ? {1'b0, 1'b1, a_q[MANT_W-1:0]} : {1'b0, 1'b1, b_q[MANT_W-1:0]};
        small_mag_d = (diff_s > SHIFT_LIM) ? '0 : (small_raw_s >> diff_s);
        // A zero operand bypasses the arithmetic entirely.
        if (a_zero_s && b_zero_s) begin
          pass_d     = 1'b1;
          pass_val_d = '0;
        end else if (a_zero_s) begin
          pass_d     = 1'b1;
          pass_val_d = {b_sign_eff_s, b_q[W-2:0]};
        end else if (b_zero_s) begin
          pass_d     = 1'b1;
          pass_val_d = a_q;
        end else begin
          pass_d     = 1'b0;
          pass_val_d = '0;
        end
      end
      ADD: begin
        state_d = NORM;
        sum_d   = eff_sub_q ? (big_mag_q - small_mag_q) : (big_mag_q + small_mag_q);
      end
      NORM: begin
        state_d = FIN;
        if (sum_q == '0) begin
          zero_d = 1'b1;
          exp_d  = big_unb_s;
          mant_d = '0;
        end else if (sum_q[MW-1]) begin
          zero_d = 1'b0;
          exp_d  = big_unb_s + ONE_S;
          mant_d = sum_q[MANT_W:1];
        end else begin
          zero_d = 1'b0;
          exp_d  = big_unb_s - $signed(EW'(lz_s));
          mant_d = norm_s;
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (pass_q) begin
          result_d = pass_val_q;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else if (zero_q) begin
          result_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else if (field_s < ONE_S) begin
          result_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
        end else if (field_s > EMAX_S) begin
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
`ifdef FPU_ADDSUB_SAT_EN
          result_d = {sign_q, EMAX_S[EXP_W-1:0], {MANT_W{1'b1}}};
`else
          result_d = {sign_q, field_s[EXP_W-1:0], mant_q};
`endif
        end else begin
          result_d = {sign_q, field_s[EXP_W-1:0], mant_q};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      pass_q      <= 1'b0;
      pass_val_q  <= '0;
      big_exp_q   <= '0;
      big_mag_q   <= '0;
      small_mag_q <= '0;
      sum_q       <= '0;
      zero_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      pass_q      <= pass_d;
      pass_val_q  <= pass_val_d;
      big_exp_q   <= big_exp_d;
      big_mag_q   <= big_mag_d;
      small_mag_q <= small_mag_d;
      sum_q       <= sum_d;
      zero_q      <= zero_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: tb/tb_fpu_addsub.sv
// Testbench for fpu_addsub: directed vectors plus random traffic checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_fpu_addsub;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 7;
  localparam int W      = 1 + EXP_W + MANT_W;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] op1   = '0;
  logic [W-1:0] op2   = '0;
  logic [W-1:0] result;
  logic         done, busy, ovf, unf;

  fpu_addsub #(.EXP_W(EXP_W), .MANT_W(MANT_W), .BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .op1(op1), .op2(op2), .result(result),
    .done(done), .busy(busy), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           cyc      = 0;
  int           next_ok  = 0;
  int           last_acc = -100;
  int           checks   = 0;
  int           fails    = 0;
  bit           mon_en   = 1'b0;
  bit           rst_at_edge = 1'b0;
  logic [W-1:0] hold_res = '0;
  logic         hold_ovf = 1'b0;
  logic         hold_unf = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: align with truncation, integer add/sub, normalise, range-check.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t        r;
    logic        sa, sbe, sgn;
    int          ea, eb, e_big, e_sml, m_big, m_sml, d, v, e;
    logic [31:0] vb, eb32;
    r.res = '0; r.ovf = 1'b0; r.unf = 1'b0; r.cyc = 0;
    sa  = a[15];
    sbe = b[15] ^ s;
    ea  = int'(a[14:7]);
    eb  = int'(b[14:7]);
    sgn = sa;
    if (ea == 0 && eb == 0) begin
      r.res = '0;
    end else if (ea == 0) begin
      r.res = {sbe, b[14:0]};
    end else if (eb == 0) begin
      r.res = a;
    end else begin
      if (a[14:0] >= b[14:0]) begin
        e_big = ea; e_sml = eb; m_big = 128 + int'(a[6:0]); m_sml = 128 + int'(b[6:0]); sgn = sa;
      end else begin
        e_big = eb; e_sml = ea; m_big = 128 + int'(b[6:0]); m_sml = 128 + int'(a[6:0]); sgn = sbe;
      end
      d = e_big - e_sml;
      if (d > MANT_W + 1) m_sml = 0;
      else m_sml = m_sml >> d;
      v = (sa != sbe) ? (m_big - m_sml) : (m_big + m_sml);
      e = e_big;
      if (v != 0) begin
        while (v >= 256) begin v = v / 2; e = e + 1; end
        while (v < 128)  begin v = v * 2; e = e - 1; end
        vb   = 32'(v);
        eb32 = 32'(e);
        if (e < 1) begin
          r.unf = 1'b1;
        end else if (e >= 255) begin
          r.ovf = 1'b1;
`ifdef FPU_ADDSUB_SAT_EN
          r.res = {sgn, 8'hFE, 7'h7F};
`else
          r.res = {sgn, eb32[7:0], vb[6:0]};
`endif
        end else begin
          r.res = {sgn, eb32[7:0], vb[6:0]};
        end
      end
    end
    return r;
  endfunction

  // Stimulus side of the scoreboard: push the expected response on each accepted start.
  always @(posedge clk) begin : model_p
    exp_t e;
    cyc = cyc + 1;
    rst_at_edge = !rst_n;
    if (!rst_n) begin
      mon_en   = 1'b1;
      next_ok  = cyc + 1;
      last_acc = -100;
    end else if (start && cyc >= next_ok) begin
      e = ref_model(op1, op2, sub);
      e.cyc = cyc + 4;
      sb_q.push_back(e);
      next_ok  = cyc + 5;
      last_acc = cyc;
    end
  end

  // Monitor: compare busy/done every cycle, pop and compare on each done.
  always @(negedge clk) begin : mon_p
    exp_t h;
    bit   exp_busy, exp_done;
    if (mon_en) begin
      if (rst_at_edge) begin
        sb_q.delete();
        hold_res = '0; hold_ovf = 1'b0; hold_unf = 1'b0;
      end
      exp_busy = (last_acc >= 0) && (cyc >= last_acc) && (cyc <= last_acc + 3);
      chk("busy", W'(busy), W'(exp_busy));
      exp_done = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
      chk("done", W'(done), W'(exp_done));
      if (exp_done) begin
        h = sb_q.pop_front();
        hold_res = h.res; hold_ovf = h.ovf; hold_unf = h.unf;
      end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        h = sb_q.pop_front();
      end
      chk("result", result, hold_res);
      chk("ovf", W'(ovf), W'(hold_ovf));
      chk("unf", W'(unf), W'(hold_unf));
    end
  end

  // Directed operation with spec-given expected values checked at start edge + 4.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [W-1:0] er, input logic eo, input logic eu);
    @(posedge clk); #2;
    op1 = a; op2 = b; sub = s; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dir_done", W'(done), W'(1'b1));
    chk("dir_result", result, er);
    chk("dir_ovf", W'(ovf), W'(eo));
    chk("dir_unf", W'(unf), W'(eu));
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [W-1:0] rand_op(input logic [W-1:0] other);
    logic [7:0] e;
    logic [7:0] oe;
    oe = other[14:7];
    case ($urandom % 8)
      0: e = 8'h00;
      1: e = ($urandom % 2 == 0) ? 8'hFE : 8'hFF;
      2: e = oe + 8'($urandom % 3) - 8'd1;
      3: return {1'($urandom), other[14:0]};
      4: e = 8'($urandom_range(1, 4));
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run(16'h3F80, 16'h3F80, 1'b0, 16'h4000, 1'b0, 1'b0);
    run(16'h4040, 16'hBF80, 1'b0, 16'h4000, 1'b0, 1'b0);
    run(16'h3FC0, 16'h3FC0, 1'b1, 16'h0000, 1'b0, 1'b0);
    run(16'h4B00, 16'h3F80, 1'b0, 16'h4B00, 1'b0, 1'b0);
    run(16'h0000, 16'h3F80, 1'b1, 16'hBF80, 1'b0, 1'b0);
`ifdef FPU_ADDSUB_SAT_EN
    run(16'h7F7F, 16'h7F7F, 1'b0, 16'h7F7F, 1'b1, 1'b0);
`else
    run(16'h7F7F, 16'h7F7F, 1'b0, 16'h7FFF, 1'b1, 1'b0);
`endif
    run(16'h0100, 16'h00C0, 1'b1, 16'h0000, 1'b0, 1'b1);

    // start held high: accepts every fifth edge.
    @(posedge clk); #2;
    op1 = 16'h3F80; op2 = 16'h4000; sub = 1'b0; start = 1'b1;
    repeat (15) @(posedge clk);
    #2 start = 1'b0;
    repeat (6) @(posedge clk);

    // Reset sampled while the operation is in ADD: no done may follow.
    #2 op1 = 16'h4040; op2 = 16'h3F80; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 800; i++) begin
      #2;
      start = ($urandom % 3 == 0);
      sub   = 1'($urandom);
      op1   = rand_op(16'h3F80);
      op2   = rand_op(op1);
      rst_n = ($urandom % 200 != 0);
      @(posedge clk);
    end
    #2 start = 1'b0; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("drain", W'(sb_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
